// File: rtl/ped_pkg.sv
// Shared types and widths for the pedestrian crossing controller.
package ped_pkg;

  localparam int unsigned PED_CNT_W = 8;

  typedef enum logic [1:0] {
    DONT_WALK = 2'b00,
    WALK      = 2'b01,
    CLEARANCE = 2'b10
  } ped_state_e;

endpackage

// File: rtl/ped_button_debounce.sv
// Push-button synchronizer, tick-based debounce counter and one-shot press pulse.
module ped_button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [3:0] DB_MAX  = 4'(DEBOUNCE_TICKS);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  logic       sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;

  // Count saturates at the threshold, so the pulse fires only once per held press.
  always_comb begin
    cnt_d   = cnt_q;
    press_o = 1'b0;
    if (tick_i) begin
      if (sync2_q) begin
        if (cnt_q != DB_MAX) cnt_d = cnt_q + 4'd1;
        if (cnt_q == DB_LAST) press_o = 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ped_crossing_controller.sv
// WALK / DON'T-WALK sequencer slaved to the vehicle light controller's red phase.
// Optional countdown output enabled by defining PED_COUNTDOWN_EN.
module ped_crossing_controller
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned WALK_TICKS     = 5,
  parameter int unsigned CLEAR_TICKS    = 4,
  parameter int unsigned FLASH_DIV      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic red,
  input  logic yellow,
  input  logic green,
  input  logic ped_button,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic light_fault
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [PED_CNT_W-1:0] countdown
`endif
);

  localparam logic [PED_CNT_W-1:0] WALK_LAST  = PED_CNT_W'(WALK_TICKS - 1);
  localparam logic [PED_CNT_W-1:0] CLEAR_LAST = PED_CNT_W'(CLEAR_TICKS - 1);
  localparam logic [3:0]           FLASH_LAST = 4'(FLASH_DIV - 1);

  ped_state_e           state_q, state_d;
  logic [PED_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           fdiv_q, fdiv_d;
  logic                 flash_q, flash_d;
  logic                 req_q, req_d;
  logic                 fault_q, fault_d;
  logic                 red_q;
  logic                 press, red_rise, lamp_bad, abort_walk, grant;

  ped_button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick),
    .btn_i  (ped_button),
    .press_o(press)
  );

  assign red_rise   = red & ~red_q;
  assign lamp_bad   = ({red, yellow, green} != 3'b100) && ({red, yellow, green} != 3'b010) &&
                      ({red, yellow, green} != 3'b001);
  assign abort_walk = ((state_q == WALK) || (state_q == CLEARANCE)) && !red;
  // A press arriving on the red-rise cycle grants even though it is not yet latched.
  assign grant      = red_rise & (req_q | press) & ~fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fdiv_d  = fdiv_q;
    flash_d = flash_q;
    case (state_q)
      DONT_WALK: if (grant) state_d = WALK;
      WALK: begin
        if (tick) begin
          if (cnt_q == WALK_LAST) state_d = CLEARANCE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      CLEARANCE: begin
        if (tick) begin
          if (fdiv_q == FLASH_LAST) begin
            flash_d = ~flash_q;
            fdiv_d  = '0;
          end else begin
            fdiv_d = fdiv_q + 4'd1;
          end
          if (cnt_q == CLEAR_LAST) state_d = DONT_WALK;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = DONT_WALK;
    endcase
    if (abort_walk || lamp_bad) state_d = DONT_WALK;
    // Every state entry restarts the timers; clearance always opens with the lamp lit.
    if (state_d != state_q) begin
      cnt_d  = '0;
      fdiv_d = '0;
      if (state_d == CLEARANCE) flash_d = 1'b1;
    end
  end

  always_comb begin
    fault_d = fault_q | abort_walk | lamp_bad;
    req_d   = req_q;
    if ((state_d == WALK) && (state_q != WALK)) req_d = 1'b0;
    else if (press && (state_q != WALK))        req_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DONT_WALK;
      cnt_q   <= '0;
      fdiv_q  <= '0;
      flash_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fdiv_q  <= fdiv_d;
      flash_q <= flash_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      red_q   <= red;
    end
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    case (state_q)
      WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      CLEARANCE: dont_walk = flash_q;
      default: ;
    endcase
  end

  assign req_pending = req_q;
  assign light_fault = fault_q;

`ifdef PED_COUNTDOWN_EN
  assign countdown = (state_q == CLEARANCE) ? (PED_CNT_W'(CLEAR_TICKS) - cnt_q) : '0;
`endif

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Scoreboard bench for ped_crossing_controller: stimulus queues expected lamp states, monitor compares.
module tb_ped_crossing_controller;

  logic clk, reset, tick, red, yellow, green, ped_button;
  logic walk, dont_walk, req_pending, light_fault;
  logic [7:0] cd_act;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown;
  assign cd_act = countdown;
`else
  assign cd_act = 8'd0;
`endif

  ped_crossing_controller #(
    .DEBOUNCE_TICKS(3),
    .WALK_TICKS    (5),
    .CLEAR_TICKS   (4),
    .FLASH_DIV     (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .ped_button (ped_button),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .light_fault(light_fault)
`ifdef PED_COUNTDOWN_EN
    ,
    .countdown  (countdown)
`endif
  );

  typedef struct {
    int         cyc;
    string      name;
    logic       w, dw, rq, f;
    logic [7:0] cd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expectation tagged for the current cycle and compares it.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] cd_exp;
    if (cyc >= 2) begin
      checks++;
      if (walk && dont_walk) begin
        errors++;
        $display("FAIL lamp_exclusive cyc=%0d walk=%b dont_walk=%b required not both 1", cyc, walk, dont_walk);
      end
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
`ifdef PED_COUNTDOWN_EN
      cd_exp = e.cd;
`else
      cd_exp = 8'd0;
`endif
      if (e.cyc != cyc || walk !== e.w || dont_walk !== e.dw || req_pending !== e.rq ||
          light_fault !== e.f || cd_act !== cd_exp) begin
        errors++;
        $display("FAIL %s cyc=%0d(exp %0d) got w=%b dw=%b req=%b flt=%b cd=%0d required w=%b dw=%b req=%b flt=%b cd=%0d",
                 e.name, cyc, e.cyc, walk, dont_walk, req_pending, light_fault, cd_act,
                 e.w, e.dw, e.rq, e.f, cd_exp);
      end
    end
  end

  task automatic step(input logic r, input logic y, input logic g, input logic b, input logic t);
    red = r; yellow = y; green = g; ped_button = b; tick = t;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic w, input logic dw, input logic rq,
                     input logic f, input int cd);
    exp_t e;
    e.cyc = cyc; e.name = name; e.w = w; e.dw = dw; e.rq = rq; e.f = f; e.cd = 8'(cd);
    q.push_back(e);
  endtask

  // Button held for 4 cycles: debounced press lands 5 edges after it goes high.
  task automatic press(input logic f);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 1); chk("press_wait", 0, 1, 0, f, 0);
    end
    step(0, 0, 1, 0, 1); chk("press_latch", 0, 1, 1, f, 0);
    step(0, 0, 1, 0, 1); chk("press_hold", 0, 1, 1, f, 0);
    step(0, 0, 1, 0, 1);
  endtask

  // Sequence after the grant edge; p=2 means tick only on every second cycle.
  task automatic tail(input int p);
    int k;
    logic t;
    k = 0;
    for (int i = 1; i < 5 * p; i++) begin
      k = i;
      t = (p == 1) ? 1'b1 : ((k % 2) == 0);
      step(1, 0, 0, 0, t); chk("walk", 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < p; j++) begin
        k++;
        t = (p == 1) ? 1'b1 : ((k % 2) == 0);
        step(1, 0, 0, 0, t); chk("clear", 0, ((i % 2) == 0), 0, 0, 4 - i);
      end
    end
    k++;
    t = (p == 1) ? 1'b1 : ((k % 2) == 0);
    step(1, 0, 0, 0, t); chk("clear_done", 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1); chk("back_green", 0, 1, 0, 0, 0);
  endtask

  task automatic run_grant(input int p);
    step(0, 1, 0, 0, 1); chk("yellow", 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, (p == 1)); chk("grant", 1, 0, 0, 0, 0);
    tail(p);
  endtask

  initial begin
    reset = 1'b1; red = 0; yellow = 0; green = 1; ped_button = 0; tick = 1;
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1); chk("reset", 0, 1, 0, 0, 0);
    reset = 1'b0;

    press(0);
    run_grant(1);

    // Glitch: two cycles high never reaches the threshold.
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1); chk("glitch_hi", 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 1); chk("glitch_lo", 0, 1, 0, 0, 0);
    end
    step(0, 1, 0, 0, 1); chk("glitch_yel", 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1); chk("glitch_red", 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1); chk("glitch_red2", 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1);

    // Press pulse on the same cycle red rises still grants.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 1); chk("coin_wait", 0, 1, 0, 0, 0);
    end
    step(1, 0, 0, 0, 1); chk("coin_grant", 1, 0, 0, 0, 0);
    tail(1);

    press(0);
    run_grant(2);

    // Abort: red drops during WALK.
    press(0);
    step(0, 1, 0, 0, 1); chk("ab_yel", 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1); chk("ab_walk1", 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1); chk("ab_walk2", 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1); chk("abort", 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1); chk("abort_sticky", 0, 1, 0, 1, 0);
    press(1);
    step(0, 1, 0, 0, 1); chk("flt_yel", 0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 1); chk("flt_nogrant", 0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 1); chk("flt_nogrant2", 0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 1);

    // Illegal lamp pattern.
    reset = 1'b1;
    step(0, 0, 1, 0, 1); chk("rst_clear", 0, 1, 0, 0, 0);
    reset = 1'b0;
    step(0, 0, 1, 0, 1); chk("legal", 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1); chk("illegal", 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1); chk("illegal_sticky", 0, 1, 0, 1, 0);
    reset = 1'b1;
    step(0, 0, 1, 0, 1); chk("rst_fault", 0, 1, 0, 0, 0);
    reset = 1'b0;

    // Reset in the middle of WALK.
    press(0);
    step(0, 1, 0, 0, 1); chk("rw_yel", 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1); chk("rw_walk1", 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1); chk("rw_walk2", 1, 0, 0, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 0, 1); chk("rst_mid_walk", 0, 1, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 0, 0, 1); chk("post_rst_red", 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1); chk("post_rst_green", 0, 1, 0, 0, 0);

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
